// File: rtl/f1_start_sequencer.sv
// Start-light sequencer for the reaction-time game: steps five lights on, holds them lit for a
// pseudo-random time, then measures the ms reaction time and flags jump starts and timeouts.
//   state  | meaning
//   IDLE   | waiting for start, all outputs low
//   LIGHTS | lights coming on one per STEP_MS ticks
//   HOLD   | all five lit for the random hold time
//   TIMING | lights out, reaction counter running
//   RESULT | result latched until the next start
module f1_start_sequencer #(
  parameter int STEP_MS     = 500,
  parameter int MIN_HOLD_MS = 200,
  parameter int RAND_BITS   = 11,
  parameter int MAX_COUNT   = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_ms,
  input  logic        start,
  input  logic        button,
  output logic [4:0]  lights,
  output logic        reactiontrigger,
  output logic [13:0] reaction_time,
  output logic        done,
  output logic        jump_start
);

  typedef enum logic [2:0] {IDLE, LIGHTS, HOLD, TIMING, RESULT} state_t;

  localparam logic [15:0] STEP_LAST  = 16'(STEP_MS - 1);
  localparam logic [15:0] HOLD_BASE  = 16'(MIN_HOLD_MS - 1);
  localparam logic [15:0] RAND_MASK  = 16'((32'd1 << RAND_BITS) - 32'd1);
  localparam logic [13:0] COUNT_LAST = 14'(MAX_COUNT - 1);
  localparam logic [13:0] COUNT_MAX  = 14'(MAX_COUNT);

  state_t      state;
  logic [15:0] step_cnt;
  logic [15:0] hold_cnt;
  logic [15:0] hold_last;
  logic [13:0] react_cnt;
  logic [15:0] lfsr;
  logic        button_q;
  logic        press;
  logic [15:0] rand_ext;

  assign press    = button & ~button_q;
  assign rand_ext = lfsr & RAND_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      step_cnt        <= '0;
      hold_cnt        <= '0;
      hold_last       <= '0;
      react_cnt       <= '0;
      lfsr            <= 16'hACE1;
      button_q        <= 1'b1;
      lights          <= '0;
      reactiontrigger <= 1'b0;
      reaction_time   <= '0;
      done            <= 1'b0;
      jump_start      <= 1'b0;
    end else begin
      button_q <= button;
      // Galois form of x^16+x^14+x^13+x^11; a nonzero seed never reaches 0
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

      unique case (state)
        IDLE, RESULT: begin
          if (start) begin
            state         <= LIGHTS;
            lights        <= 5'b00001;
            step_cnt      <= '0;
            reaction_time <= '0;
            done          <= 1'b0;
            jump_start    <= 1'b0;
          end
        end

        LIGHTS, HOLD: begin
          if (press) begin
            state         <= RESULT;
            lights        <= '0;
            reaction_time <= '0;
            jump_start    <= 1'b1;
            done          <= 1'b1;
          end else if (tick_ms && state == LIGHTS) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              lights   <= {lights[3:0], 1'b1};
              if (lights[3:0] == 4'b1111) begin
                state     <= HOLD;
                hold_cnt  <= '0;
                hold_last <= HOLD_BASE + rand_ext;
              end
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end else if (tick_ms) begin
            if (hold_cnt == hold_last) begin
              state           <= TIMING;
              lights          <= '0;
              react_cnt       <= '0;
              reactiontrigger <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
        end

        TIMING: begin
          // a press on a tick cycle records the count before that tick
          if (press) begin
            state           <= RESULT;
            reaction_time   <= react_cnt;
            reactiontrigger <= 1'b0;
            done            <= 1'b1;
          end else if (tick_ms) begin
            if (react_cnt == COUNT_LAST) begin
              state           <= RESULT;
              reaction_time   <= COUNT_MAX;
              reactiontrigger <= 1'b0;
              done            <= 1'b1;
            end else begin
              react_cnt <= react_cnt + 14'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Directed bench for f1_start_sequencer: a short-cadence instance for the main flow and a
// MAX_COUNT=20 instance, in lockstep on the same inputs, for the timeout case.
module tb_f1_start_sequencer;

  logic        clk = 1'b0;
  logic        rst, tick_ms, start, button;
  logic [4:0]  lights, lights_t;
  logic        trig, trig_t, done, done_t, js, js_t;
  logic [13:0] rt, rt_t;

  int n_vec = 0;
  int n_err = 0;
  int hold_ticks;
  logic [4:0] exp_l;

  always #5 clk = ~clk;

  f1_start_sequencer #(.STEP_MS(2), .MIN_HOLD_MS(3), .RAND_BITS(2), .MAX_COUNT(9999)) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .start(start), .button(button),
    .lights(lights), .reactiontrigger(trig), .reaction_time(rt), .done(done), .jump_start(js)
  );

  f1_start_sequencer #(.STEP_MS(2), .MIN_HOLD_MS(3), .RAND_BITS(2), .MAX_COUNT(20)) dut_to (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .start(start), .button(button),
    .lights(lights_t), .reactiontrigger(trig_t), .reaction_time(rt_t), .done(done_t),
    .jump_start(js_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one ms tick followed by three idle clocks
  task automatic tick4();
    tick_ms = 1'b1;
    step();
    tick_ms = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic press();
    button = 1'b1;
    step();
    button = 1'b0;
    step();
  endtask

  // from a fresh LIGHTS entry: eight ticks to all-lit, then count hold ticks until lights out
  task automatic run_to_timing(output int n);
    repeat (8) tick4();
    n = 0;
    while (lights != 5'b0 && n < 10) begin
      tick4();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; tick_ms = 1'b0; start = 1'b0; button = 1'b0;
    repeat (2) step();
    chk("rst_lights", 32'(lights), 0);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_rt", 32'(rt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_js", 32'(js), 0);
    rst = 1'b0;
    repeat (2) step();

    // normal run
    pulse_start();
    chk("first_light", 32'(lights), 32'b00001);
    exp_l = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      tick4();
      chk("light_hold", 32'(lights), 32'(exp_l));
      tick4();
      exp_l = {exp_l[3:0], 1'b1};
      chk("light_step", 32'(lights), 32'(exp_l));
    end
    pulse_start();
    chk("start_in_hold", 32'(lights), 32'b11111);
    hold_ticks = 0;
    while (lights != 5'b0 && hold_ticks < 10) begin
      tick4();
      hold_ticks++;
    end
    chk("hold_range", 32'(hold_ticks >= 3 && hold_ticks <= 6), 1);
    chk("out_trig", 32'(trig), 1);
    chk("out_done", 32'(done), 0);
    repeat (37) tick4();
    button = 1'b1;
    step();
    button = 1'b0;
    chk("norm_rt", 32'(rt), 37);
    chk("norm_done", 32'(done), 1);
    chk("norm_trig", 32'(trig), 0);
    chk("norm_js", 32'(js), 0);
    step();

    // restart from RESULT, then jump start at 00111
    pulse_start();
    chk("restart_done", 32'(done), 0);
    chk("restart_rt", 32'(rt), 0);
    chk("restart_lights", 32'(lights), 32'b00001);
    repeat (4) tick4();
    chk("js_pre_lights", 32'(lights), 32'b00111);
    button = 1'b1;
    step();
    button = 1'b0;
    chk("js_lights", 32'(lights), 0);
    chk("js_flag", 32'(js), 1);
    chk("js_done", 32'(done), 1);
    chk("js_rt", 32'(rt), 0);
    step();
    repeat (2) tick4();
    press();
    chk("js_hold_lights", 32'(lights), 0);
    chk("js_hold_flag", 32'(js), 1);
    chk("js_hold_rt", 32'(rt), 0);
    chk("js_hold_done", 32'(done), 1);

    // tick/press collision
    pulse_start();
    run_to_timing(hold_ticks);
    chk("col_hold_range", 32'(hold_ticks >= 3 && hold_ticks <= 6), 1);
    repeat (12) tick4();
    tick_ms = 1'b1;
    button = 1'b1;
    step();
    tick_ms = 1'b0;
    button = 1'b0;
    chk("col_rt", 32'(rt), 12);
    chk("col_done", 32'(done), 1);
    step();

    // timeout on the MAX_COUNT=20 instance
    pulse_start();
    run_to_timing(hold_ticks);
    chk("to_hold_range", 32'(hold_ticks >= 3 && hold_ticks <= 6), 1);
    chk("to_trig_on", 32'(trig_t), 1);
    repeat (19) tick4();
    chk("to_pre_done", 32'(done_t), 0);
    tick4();
    chk("to_rt", 32'(rt_t), 20);
    chk("to_done", 32'(done_t), 1);
    chk("to_trig", 32'(trig_t), 0);
    chk("to_js", 32'(js_t), 0);
    chk("to_other_trig", 32'(trig), 1);

    // async reset mid-TIMING with button held high
    #2;
    rst = 1'b1;
    button = 1'b1;
    #1;
    chk("arst_trig", 32'(trig), 0);
    chk("arst_done", 32'(done), 0);
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    chk("arst_lights", 32'(lights), 0);
    chk("arst_rt", 32'(rt), 0);
    chk("arst_done2", 32'(done), 0);
    chk("arst_js", 32'(js), 0);
    pulse_start();
    chk("arst_start_lights", 32'(lights), 32'b00001);
    repeat (2) tick4();
    chk("arst_no_edge_js", 32'(js), 0);
    chk("arst_no_edge_lights", 32'(lights), 32'b00011);
    button = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
